id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between decode (register file read) and execute.
- Latches the register-file read data, register numbers, the immediate and the decoded control bits.
- Bypasses the same-cycle write-back write, and forwards EX/MEM and MEM/WB results into the ALU operands.
- Detects load-use hazards and inserts bubbles on stall or flush.

Parameters:
DATA_WIDTH, 32, operand/result width
REG_ADDR_WIDTH, 5, register number width (32 registers, register 0 hardwired zero)
ALUOP_WIDTH, 4, ALU operation code width

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  asynchronous active-high reset
id_valid  in  1  decode slot holds a real instruction
flush  in  1  branch/jump taken; discard instruction entering EX
read_data_1  in  DATA_WIDTH  register file port 1 data (rs)
read_data_2  in  DATA_WIDTH  register file port 2 data (rt)
read_register_1  in  REG_ADDR_WIDTH  rs number
read_register_2  in  REG_ADDR_WIDTH  rt number
id_rd  in  REG_ADDR_WIDTH  rd field
id_imm  in  DATA_WIDTH  sign/zero-extended immediate
id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst  in  1 each  decoded control bits
id_ALUOp  in  ALUOP_WIDTH  ALU operation
ex_mem_RegWrite  in  1  EX/MEM instruction writes a register
ex_mem_write_register  in  REG_ADDR_WIDTH  EX/MEM destination
ex_mem_alu_result  in  DATA_WIDTH  EX/MEM ALU result
mem_wb_RegWrite  in  1  write-back enable (same signal driving register file RegWrite)
mem_wb_write_register  in  REG_ADDR_WIDTH  write-back destination
mem_wb_write_data  in  DATA_WIDTH  write-back data
hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  EX slot holds a real instruction
ex_operand_a  out  DATA_WIDTH  forwarded rs value
ex_operand_b  out  DATA_WIDTH  ALUSrc ? immediate : forwarded rt value
ex_store_data  out  DATA_WIDTH  forwarded rt value (for stores)
ex_write_register  out  REG_ADDR_WIDTH  destination (RegDst ? rd : rt)
ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg  out  1 each  latched control
ex_ALUOp  out  ALUOP_WIDTH  latched ALU operation

Behaviour:
- Reset (async, any time): all latched state is 0, so ex_valid=0, all control 0, data/register outputs 0, and hazard_stall=0. Reset mid-stall drops the stall immediately.
- Hazard detect (combinational from latched state): hazard_stall = ex_valid & ex_MemRead & ex_write_register!=0 & id_valid & (ex_write_register==read_register_1 | ex_write_register==read_register_2). The rt compare is always made; this is conservative by design.
- Latch priority at each rising edge:
  - flush: load a bubble.
  - else hazard_stall: load a bubble.
  - else: load the decode slot, with ex_valid=id_valid.
- Bubble: ex_valid=0 and RegWrite/MemRead/MemWrite/MemtoReg=0. Data fields are don't-care but are loaded as 0.
- Write-through bypass at latch: if mem_wb_RegWrite & mem_wb_write_register!=0 & mem_wb_write_register==read_register_N, latch mem_wb_write_data instead of read_data_N. This is required because the register file writes on the same edge and reads asynchronously.
- Destination: latched as id_RegDst ? id_rd : read_register_2. ALUSrc and the immediate are latched too.
- EX forwarding (combinational on latched rs/rt), applied per operand, highest priority first:
  1. ex_mem_RegWrite & dest!=0 & dest==rs → ex_mem_alu_result.
  2. else mem_wb_RegWrite & dest!=0 & dest==rs → mem_wb_write_data.
  3. else the latched value.
  - The same rule applies for rt, feeding ex_store_data and the non-immediate ex_operand_b.
- Register 0 is never forwarded or bypassed; reads of r0 yield the latched value, which the register file guarantees is 0.
- Latency: one cycle from decode to EX outputs; a load-use hazard costs exactly one bubble.
- Simultaneous flush and stall: bubble loaded once. hazard_stall may still assert, and upstream honours flush.

Test Plan:
- Reset asserted mid-operation with ex_valid=1 → ex_valid, all control bits and hazard_stall go 0 without waiting for a clock edge.
- add r3 (result 0x00000005) followed by a dependent add rs=r3 → ex_operand_a=0x00000005, taken from ex_mem_alu_result. With both EX/MEM and MEM/WB targeting r3 (values 5 and 9) → ex_operand_a=5.
- lw r4 followed by add rs=r4 → hazard_stall=1 for one cycle; next edge ex_valid=0 with zero control; following edge the add enters, with a MEM/WB match on r4 forwarding the load data.
- mem_wb writes r7=0xDEADBEEF on the same edge decode reads r7 (read_data_1=0x11111111) → latched ex_operand_a=0xDEADBEEF.
- Instruction writing r0 in EX/MEM (result 0x1234) with next rs=r0 → ex_operand_a=latched value 0, no forward.
- flush=1 with id_valid=1 and a stall condition present → ex_valid=0, ex_MemWrite=0 after the edge.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode slot, forwarding sources and the latched EX slot.
// The master side (decode / pipeline control) drives the decode and
// forwarding signals; the slave side (the ID/EX stage) drives the EX outputs.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 4
);
    // decode slot
    logic                      id_valid;
    logic                      flush;
    logic [DATA_WIDTH-1:0]     read_data_1;
    logic [DATA_WIDTH-1:0]     read_data_2;
    logic [REG_ADDR_WIDTH-1:0] read_register_1;
    logic [REG_ADDR_WIDTH-1:0] read_register_2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic                      id_RegWrite;
    logic                      id_MemRead;
    logic                      id_MemWrite;
    logic                      id_MemtoReg;
    logic                      id_ALUSrc;
    logic                      id_RegDst;
    logic [ALUOP_WIDTH-1:0]    id_ALUOp;
    // forwarding sources from later stages
    logic                      ex_mem_RegWrite;
    logic [REG_ADDR_WIDTH-1:0] ex_mem_write_register;
    logic [DATA_WIDTH-1:0]     ex_mem_alu_result;
    logic                      mem_wb_RegWrite;
    logic [REG_ADDR_WIDTH-1:0] mem_wb_write_register;
    logic [DATA_WIDTH-1:0]     mem_wb_write_data;
    // EX slot
    logic                      hazard_stall;
    logic                      ex_valid;
    logic [DATA_WIDTH-1:0]     ex_operand_a;
    logic [DATA_WIDTH-1:0]     ex_operand_b;
    logic [DATA_WIDTH-1:0]     ex_store_data;
    logic [REG_ADDR_WIDTH-1:0] ex_write_register;
    logic                      ex_RegWrite;
    logic                      ex_MemRead;
    logic                      ex_MemWrite;
    logic                      ex_MemtoReg;
    logic [ALUOP_WIDTH-1:0]    ex_ALUOp;

    modport master (
        output id_valid, flush, read_data_1, read_data_2, read_register_1,
               read_register_2, id_rd, id_imm, id_RegWrite, id_MemRead,
               id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst, id_ALUOp,
               ex_mem_RegWrite, ex_mem_write_register, ex_mem_alu_result,
               mem_wb_RegWrite, mem_wb_write_register, mem_wb_write_data,
        input  hazard_stall, ex_valid, ex_operand_a, ex_operand_b, ex_store_data,
               ex_write_register, ex_RegWrite, ex_MemRead, ex_MemWrite,
               ex_MemtoReg, ex_ALUOp
    );

    modport slave (
        input  id_valid, flush, read_data_1, read_data_2, read_register_1,
               read_register_2, id_rd, id_imm, id_RegWrite, id_MemRead,
               id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst, id_ALUOp,
               ex_mem_RegWrite, ex_mem_write_register, ex_mem_alu_result,
               mem_wb_RegWrite, mem_wb_write_register, mem_wb_write_data,
        output hazard_stall, ex_valid, ex_operand_a, ex_operand_b, ex_store_data,
               ex_write_register, ex_RegWrite, ex_MemRead, ex_MemWrite,
               ex_MemtoReg, ex_ALUOp
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-through bypass at latch time,
// EX/MEM and MEM/WB operand forwarding, and load-use bubble insertion.
// Operand index 0 is rs (port 1), index 1 is rt (port 2).
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = REG_ADDR_WIDTH;
    localparam int OW = ALUOP_WIDTH;

    // latched EX slot
    logic          valid_reg,    valid_next;
    logic [AW-1:0] src_num_reg  [2];
    logic [AW-1:0] src_num_next [2];
    logic [DW-1:0] src_data_reg [2];
    logic [DW-1:0] src_data_next[2];
    logic [DW-1:0] imm_reg,      imm_next;
    logic [AW-1:0] dest_reg,     dest_next;
    logic          regwrite_reg, regwrite_next;
    logic          memread_reg,  memread_next;
    logic          memwrite_reg, memwrite_next;
    logic          memtoreg_reg, memtoreg_next;
    logic          alusrc_reg,   alusrc_next;
    logic [OW-1:0] aluop_reg,    aluop_next;

    // per-operand views of the decode slot and the forwarded result
    logic [AW-1:0] id_src_num  [2];
    logic [DW-1:0] id_src_data [2];
    logic [DW-1:0] bypass_data [2];
    logic [DW-1:0] fwd_data    [2];

    logic hazard_stall;
    logic load_bubble;

    assign id_src_num[0]  = bus.read_register_1;
    assign id_src_num[1]  = bus.read_register_2;
    assign id_src_data[0] = bus.read_data_1;
    assign id_src_data[1] = bus.read_data_2;

    // Load-use hazard: the load in EX cannot supply its data until MEM/WB.
    // The rt compare is made even when rt is not a real source operand.
    assign hazard_stall = valid_reg & memread_reg & (dest_reg != '0) & bus.id_valid &
                          ((dest_reg == bus.read_register_1) |
                           (dest_reg == bus.read_register_2));

    assign load_bubble = bus.flush | hazard_stall;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            // The register file writes on the same edge we sample, so take
            // the write-back value directly when it targets this source.
            assign bypass_data[gi] =
                (bus.mem_wb_RegWrite && (bus.mem_wb_write_register != '0) &&
                 (bus.mem_wb_write_register == id_src_num[gi]))
                ? bus.mem_wb_write_data : id_src_data[gi];

            // EX forwarding: the younger EX/MEM result wins over MEM/WB.
            assign fwd_data[gi] =
                (bus.ex_mem_RegWrite && (bus.ex_mem_write_register != '0) &&
                 (bus.ex_mem_write_register == src_num_reg[gi]))
                ? bus.ex_mem_alu_result :
                (bus.mem_wb_RegWrite && (bus.mem_wb_write_register != '0) &&
                 (bus.mem_wb_write_register == src_num_reg[gi]))
                ? bus.mem_wb_write_data : src_data_reg[gi];

            // Next source number/data: zero on a bubble, else the decode slot.
            always_comb begin
                src_num_next[gi]  = '0;
                src_data_next[gi] = '0;
                if (!load_bubble) begin
                    src_num_next[gi]  = id_src_num[gi];
                    src_data_next[gi] = bypass_data[gi];
                end
            end

            // Latch the source register number and its (bypassed) value.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    src_num_reg[gi]  <= '0;
                    src_data_reg[gi] <= '0;
                end else begin
                    src_num_reg[gi]  <= src_num_next[gi];
                    src_data_reg[gi] <= src_data_next[gi];
                end
            end
        end
    endgenerate

    // Next control/immediate/destination: a bubble zeroes everything.
    always_comb begin
        valid_next    = 1'b0;
        imm_next      = '0;
        dest_next     = '0;
        regwrite_next = 1'b0;
        memread_next  = 1'b0;
        memwrite_next = 1'b0;
        memtoreg_next = 1'b0;
        alusrc_next   = 1'b0;
        aluop_next    = '0;
        if (!load_bubble) begin
            valid_next    = bus.id_valid;
            imm_next      = bus.id_imm;
            dest_next     = bus.id_RegDst ? bus.id_rd : bus.read_register_2;
            regwrite_next = bus.id_RegWrite;
            memread_next  = bus.id_MemRead;
            memwrite_next = bus.id_MemWrite;
            memtoreg_next = bus.id_MemtoReg;
            alusrc_next   = bus.id_ALUSrc;
            aluop_next    = bus.id_ALUOp;
        end
    end

    // Latch the control and immediate fields of the EX slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg    <= 1'b0;
            imm_reg      <= '0;
            dest_reg     <= '0;
            regwrite_reg <= 1'b0;
            memread_reg  <= 1'b0;
            memwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            alusrc_reg   <= 1'b0;
            aluop_reg    <= '0;
        end else begin
            valid_reg    <= valid_next;
            imm_reg      <= imm_next;
            dest_reg     <= dest_next;
            regwrite_reg <= regwrite_next;
            memread_reg  <= memread_next;
            memwrite_reg <= memwrite_next;
            memtoreg_reg <= memtoreg_next;
            alusrc_reg   <= alusrc_next;
            aluop_reg    <= aluop_next;
        end
    end

    assign bus.hazard_stall      = hazard_stall;
    assign bus.ex_valid          = valid_reg;
    assign bus.ex_operand_a      = fwd_data[0];
    assign bus.ex_operand_b      = alusrc_reg ? imm_reg : fwd_data[1];
    assign bus.ex_store_data     = fwd_data[1];
    assign bus.ex_write_register = dest_reg;
    assign bus.ex_RegWrite       = regwrite_reg;
    assign bus.ex_MemRead        = memread_reg;
    assign bus.ex_MemWrite       = memwrite_reg;
    assign bus.ex_MemtoReg       = memtoreg_reg;
    assign bus.ex_ALUOp          = aluop_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus hand-written sequences
// for load-use, flush-with-stall and asynchronous reset.
module tb_id_ex_stage;
    logic clk;
    logic reset;

    id_ex_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(4)) bus ();

    id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ctrl nibble order: {RegWrite, MemRead, MemWrite, MemtoReg}
    typedef struct {
        logic        v, fl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0]  ctrl;
        logic        alusrc, regdst;
        logic [3:0]  aluop;
        logic        pw_en;  logic [4:0] pw_reg;  logic [31:0] pw_data;  // MEM/WB at the latch edge
        logic        em_en;  logic [4:0] em_reg;  logic [31:0] em_data;  // EX/MEM after the edge
        logic        wb_en;  logic [4:0] wb_reg;  logic [31:0] wb_data;  // MEM/WB after the edge
        logic        e_valid;
        logic [31:0] e_a, e_b, e_st;
        logic [4:0]  e_wr;
        logic [3:0]  e_ctrl;
        logic [3:0]  e_aluop;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_fwd(input logic em_en, input logic [4:0] em_reg, input logic [31:0] em_data,
                           input logic wb_en, input logic [4:0] wb_reg, input logic [31:0] wb_data);
        bus.ex_mem_RegWrite       = em_en;
        bus.ex_mem_write_register = em_reg;
        bus.ex_mem_alu_result     = em_data;
        bus.mem_wb_RegWrite       = wb_en;
        bus.mem_wb_write_register = wb_reg;
        bus.mem_wb_write_data     = wb_data;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [3:0] ctrl, input logic alusrc,
                            input logic regdst, input logic [3:0] aluop);
        bus.id_valid        = v;
        bus.read_register_1 = rs;
        bus.read_register_2 = rt;
        bus.id_rd           = rd;
        bus.read_data_1     = d1;
        bus.read_data_2     = d2;
        bus.id_imm          = imm;
        {bus.id_RegWrite, bus.id_MemRead, bus.id_MemWrite, bus.id_MemtoReg} = ctrl;
        bus.id_ALUSrc       = alusrc;
        bus.id_RegDst       = regdst;
        bus.id_ALUOp        = aluop;
    endtask

    function automatic logic [3:0] ex_ctrl();
        return {bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemtoReg};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h99, 4'b1000, 1'b0, 1'b1, 4'd2,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h10, 32'h20, 32'h20, 5'd3, 4'b1000, 4'd2};
        vecs[1] = '{1'b1, 1'b0, 5'd3, 5'd5, 5'd6, 32'h0, 32'h7, 32'h0, 4'b1000, 1'b0, 1'b1, 4'd2,
                    1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h5, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h5, 32'h7, 32'h7, 5'd6, 4'b1000, 4'd2};
        vecs[2] = '{1'b1, 1'b0, 5'd3, 5'd3, 5'd8, 32'h0, 32'h0, 32'h0, 4'b1000, 1'b0, 1'b1, 4'd2,
                    1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h5, 1'b1, 5'd3, 32'h9,
                    1'b1, 32'h5, 32'h5, 32'h5, 5'd8, 4'b1000, 4'd2};
        vecs[3] = '{1'b1, 1'b0, 5'd1, 5'd4, 5'd10, 32'h1, 32'h2, 32'h0, 4'b1000, 1'b0, 1'b1, 4'd3,
                    1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h55, 1'b1, 5'd4, 32'hAB,
                    1'b1, 32'h1, 32'hAB, 32'hAB, 5'd10, 4'b1000, 4'd3};
        vecs[4] = '{1'b1, 1'b0, 5'd7, 5'd2, 5'd11, 32'h11111111, 32'h22, 32'h0, 4'b1000, 1'b0, 1'b1, 4'd2,
                    1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'hDEADBEEF, 32'h22, 32'h22, 5'd11, 4'b1000, 4'd2};
        vecs[5] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 4'b1000, 1'b0, 1'b0, 4'd2,
                    1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h77,
                    1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 4'b1000, 4'd2};
        vecs[6] = '{1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h100, 32'h200, 32'h8, 4'b0010, 1'b1, 1'b0, 4'd0,
                    1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h333, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h100, 32'h8, 32'h333, 5'd2, 4'b0010, 4'd0};
        vecs[7] = '{1'b0, 1'b0, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h0, 4'b1000, 1'b0, 1'b1, 4'd1,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b0, 32'h50, 32'h60, 32'h60, 5'd7, 4'b1000, 4'd1};
        vecs[8] = '{1'b1, 1'b1, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h4, 4'b1100, 1'b1, 1'b1, 4'd1,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000, 4'd0};
        vecs[9] = '{1'b1, 1'b0, 5'd1, 5'd4, 5'd9, 32'h1000, 32'h77, 32'h40, 4'b1101, 1'b1, 1'b0, 4'd0,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                    1'b1, 32'h1000, 32'h40, 32'h77, 5'd4, 4'b1101, 4'd0};

        // reset state
        reset = 1'b1;
        bus.flush = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        check("rst_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_ctrl", 32'(ex_ctrl()), 32'd0);
        check("rst_stall", 32'(bus.hazard_stall), 32'd0);
        check("rst_wr", 32'(bus.ex_write_register), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // table-driven single-cycle vectors
        for (int i = 0; i < 10; i++) begin
            drive_id(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].d1, vecs[i].d2,
                     vecs[i].imm, vecs[i].ctrl, vecs[i].alusrc, vecs[i].regdst, vecs[i].aluop);
            bus.flush = vecs[i].fl;
            set_fwd(1'b0, 5'd0, 32'h0, vecs[i].pw_en, vecs[i].pw_reg, vecs[i].pw_data);
            #1;
            check($sformatf("v%0d_stall", i), 32'(bus.hazard_stall), 32'd0);
            @(posedge clk); #1;
            bus.flush = 1'b0;
            set_fwd(vecs[i].em_en, vecs[i].em_reg, vecs[i].em_data,
                    vecs[i].wb_en, vecs[i].wb_reg, vecs[i].wb_data);
            #1;
            check($sformatf("v%0d_valid", i), 32'(bus.ex_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_a", i), bus.ex_operand_a, vecs[i].e_a);
            check($sformatf("v%0d_b", i), bus.ex_operand_b, vecs[i].e_b);
            check($sformatf("v%0d_st", i), bus.ex_store_data, vecs[i].e_st);
            check($sformatf("v%0d_wr", i), 32'(bus.ex_write_register), 32'(vecs[i].e_wr));
            check($sformatf("v%0d_ctrl", i), 32'(ex_ctrl()), 32'(vecs[i].e_ctrl));
            check($sformatf("v%0d_aluop", i), 32'(bus.ex_ALUOp), 32'(vecs[i].e_aluop));
            $display("vec %0d: valid=%0b a=%h b=%h st=%h wr=%0d ctrl=%b aluop=%0d", i,
                     bus.ex_valid, bus.ex_operand_a, bus.ex_operand_b, bus.ex_store_data,
                     bus.ex_write_register, ex_ctrl(), bus.ex_ALUOp);
        end

        // load-use: lw r4 is in EX; add r6 = r4 + r5 waits one bubble
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive_id(1'b1, 5'd4, 5'd5, 5'd6, 32'h0, 32'h3, 32'h0, 4'b1000, 1'b0, 1'b1, 4'd2);
        #1;
        check("lu_stall", 32'(bus.hazard_stall), 32'd1);
        @(posedge clk); #1;
        check("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        check("lu_bubble_ctrl", 32'(ex_ctrl()), 32'd0);
        check("lu_stall_clear", 32'(bus.hazard_stall), 32'd0);
        $display("load-use bubble: valid=%0b ctrl=%b stall=%0b", bus.ex_valid, ex_ctrl(), bus.hazard_stall);
        @(posedge clk); #1;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hCAFE00);
        #1;
        check("lu_add_valid", 32'(bus.ex_valid), 32'd1);
        check("lu_add_a", bus.ex_operand_a, 32'hCAFE00);
        check("lu_add_wr", 32'(bus.ex_write_register), 32'd6);
        $display("load-use add: valid=%0b a=%h wr=%0d", bus.ex_valid, bus.ex_operand_a, bus.ex_write_register);

        // rt-only match stalls; flush wins with a bubble
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        drive_id(1'b1, 5'd1, 5'd4, 5'd0, 32'h10, 32'h0, 32'h4, 4'b1101, 1'b1, 1'b0, 4'd0);
        @(posedge clk); #1;
        drive_id(1'b1, 5'd8, 5'd4, 5'd9, 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b0, 4'd0);
        bus.flush = 1'b1;
        #1;
        check("rt_stall", 32'(bus.hazard_stall), 32'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("fl_valid", 32'(bus.ex_valid), 32'd0);
        check("fl_memwrite", 32'(bus.ex_MemWrite), 32'd0);
        $display("flush+stall: valid=%0b memwrite=%0b", bus.ex_valid, bus.ex_MemWrite);

        // asynchronous reset in the middle of a stall
        drive_id(1'b1, 5'd1, 5'd4, 5'd0, 32'h10, 32'h0, 32'h4, 4'b1101, 1'b1, 1'b0, 4'd0);
        @(posedge clk); #1;
        drive_id(1'b1, 5'd4, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, 4'b1000, 1'b0, 1'b1, 4'd2);
        #1;
        check("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
        check("pre_rst_stall", 32'(bus.hazard_stall), 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.ex_valid), 32'd0);
        check("async_rst_ctrl", 32'(ex_ctrl()), 32'd0);
        check("async_rst_stall", 32'(bus.hazard_stall), 32'd0);
        check("async_rst_wr", 32'(bus.ex_write_register), 32'd0);
        $display("async reset: valid=%0b ctrl=%b stall=%0b", bus.ex_valid, ex_ctrl(), bus.hazard_stall);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
